sdram_init_checker: RTL and testbench

//   Synthesizable, parametrised monitor of the SDRAM power-up/initialisation command sequence.
//   - Checks: power-up NOP window -> PRECHARGE -> N x AUTO-REFRESH -> LOAD-MODE-REGISTER -> sdr_init_done.
//   - Every timing gap (tRP, tRFC, tMRD, done timeout) is a parameter.
//   - Taps the controller's SDRAM command pins and init_done; drives pass/fail status and the first error code.
//   - Runs in the same clock as the SDRAM controller (synchronous-clock configuration).

---
 rtl/sdram_init_checker.sv | 152 +++++++++++++++
 tb/tb_sdram_init_checker.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_init_checker.sv
// Passive monitor of the SDRAM power-up command sequence; flags the first violation.
// Latency: status registered 1 cycle after the offending sample; backpressure: none, pure tap.
module sdram_init_checker #(
    parameter int T_PWRUP = 500,
    parameter int T_RP    = 2,
    parameter int T_RFC   = 7,
    parameter int N_AREF  = 2,
    parameter int T_MRD   = 2,
    parameter int T_DONE  = 8,
    parameter int CNT_W   = 16
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             sdr_cke,
    input  logic             sdr_cs_n,
    input  logic             sdr_ras_n,
    input  logic             sdr_cas_n,
    input  logic             sdr_we_n,
    input  logic             sdr_init_done,
    output logic             init_ok,
    output logic             init_err,
    output logic [3:0]       err_code,
    output logic [3:0]       aref_cnt,
    output logic [CNT_W-1:0] init_cycles,
    output logic [2:0]       chk_state
);

    typedef enum logic [2:0] {
        S_PWRUP     = 3'd0,
        S_WAIT_RP   = 3'd1,
        S_WAIT_RFC  = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_RUN       = 3'd4,
        S_FAIL      = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] L_PWRUP = CNT_W'(T_PWRUP);
    localparam logic [CNT_W-1:0] L_RP    = CNT_W'(T_RP);
    localparam logic [CNT_W-1:0] L_RFC   = CNT_W'(T_RFC);
    localparam logic [CNT_W-1:0] L_MRD   = CNT_W'(T_MRD);
    localparam logic [CNT_W-1:0] L_DONE  = CNT_W'(T_DONE);
    localparam logic [3:0]       L_NAREF = 4'(N_AREF);

    state_t           r_state, w_next;
    logic [CNT_W-1:0] r_gap, r_cyc, r_init_cycles;
    logic [3:0]       r_aref, w_aref_nxt, r_err_code, w_code;
    logic             r_init_ok, r_init_err;
    logic [10:1]      w_v;
    logic             w_nop, w_pre, w_aref, w_mrs;

    assign w_nop  = sdr_cs_n | (sdr_ras_n & sdr_cas_n & sdr_we_n);
    assign w_pre  = ~sdr_cs_n & ~sdr_ras_n &  sdr_cas_n & ~sdr_we_n;
    assign w_aref = ~sdr_cs_n & ~sdr_ras_n & ~sdr_cas_n &  sdr_we_n;
    assign w_mrs  = ~sdr_cs_n & ~sdr_ras_n & ~sdr_cas_n & ~sdr_we_n;

    always_comb begin
        w_next     = r_state;
        w_aref_nxt = r_aref;
        w_v        = '0;
        w_code     = 4'd0;
        case (r_state)
            S_PWRUP: begin
                if (!w_nop) begin
                    if (w_pre && r_gap >= L_PWRUP) w_next = S_WAIT_RP;
                    else                           w_v[1] = 1'b1;
                end
            end
            S_WAIT_RP: begin
                if (!w_nop) begin
                    if (r_gap < L_RP) w_v[3] = 1'b1;
                    if (w_aref) begin
                        w_aref_nxt = 4'd1;
                        w_next     = S_WAIT_RFC;
                    end else begin
                        w_v[2] = 1'b1;
                    end
                end
            end
            S_WAIT_RFC: begin
                if (!w_nop) begin
                    if (r_gap < L_RFC) w_v[4] = 1'b1;
                    if (w_aref) begin
                        if (r_aref != 4'hF) w_aref_nxt = r_aref + 4'd1;
                    end else if (w_mrs) begin
                        if (r_aref >= L_NAREF) w_next = S_WAIT_DONE;
                        else                   w_v[5] = 1'b1;
                    end else begin
                        w_v[2] = 1'b1;
                    end
                end
            end
            S_WAIT_DONE: begin
                if (!w_nop && r_gap < L_MRD) w_v[6] = 1'b1;
                if (sdr_init_done)           w_next = S_RUN;
                else if (r_gap >= L_DONE)    w_v[7] = 1'b1;
            end
            S_RUN: begin
                if (!sdr_init_done) w_v[9] = 1'b1;
            end
            default: ;
        endcase

        if (r_state inside {S_PWRUP, S_WAIT_RP, S_WAIT_RFC} && sdr_init_done)
            w_v[8] = 1'b1;
        if (r_state inside {S_WAIT_RP, S_WAIT_RFC, S_WAIT_DONE, S_RUN} && !sdr_cke)
            w_v[10] = 1'b1;

        // Lowest code wins among ordinary checks; 10 then 8 override on top.
        for (int i = 9; i >= 1; i--) begin
            if (w_v[i]) w_code = 4'(i);
        end
        if (w_v[10]) w_code = 4'd10;
        if (w_v[8])  w_code = 4'd8;

        if (w_code != 4'd0) w_next = S_FAIL;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state       <= S_PWRUP;
            r_gap         <= '0;
            r_cyc         <= '0;
            r_init_cycles <= '0;
            r_aref        <= 4'd0;
            r_err_code    <= 4'd0;
            r_init_ok     <= 1'b0;
            r_init_err    <= 1'b0;
        end else begin
            r_state <= w_next;
            r_aref  <= w_aref_nxt;
            if (!w_nop)         r_gap <= CNT_W'(1);
            else if (!(&r_gap)) r_gap <= r_gap + 1'b1;
            if (r_state != S_RUN && r_state != S_FAIL && !(&r_cyc))
                r_cyc <= r_cyc + 1'b1;
            if (w_next != r_state && (w_next == S_RUN || w_next == S_FAIL))
                r_init_cycles <= r_cyc;
            if (w_code != 4'd0) begin
                r_init_err <= 1'b1;
                r_err_code <= w_code;
            end
            if (w_next == S_RUN) r_init_ok <= 1'b1;
        end
    end

    assign init_ok     = r_init_ok;
    assign init_err    = r_init_err;
    assign err_code    = r_err_code;
    assign aref_cnt    = r_aref;
    assign init_cycles = r_init_cycles;
    assign chk_state   = r_state;

endmodule

// File: tb/tb_sdram_init_checker.sv
// Directed bench for sdram_init_checker with short timing parameters.
module tb_sdram_init_checker;

    localparam int CNT_W = 16;
    localparam logic [3:0] C_NOP  = 4'b0111;
    localparam logic [3:0] C_PRE  = 4'b0010;
    localparam logic [3:0] C_AREF = 4'b0001;
    localparam logic [3:0] C_MRS  = 4'b0000;

    logic             clk = 1'b0;
    logic             rst;
    logic             cke, cs_n, ras_n, cas_n, we_n, done;
    logic             init_ok, init_err;
    logic [3:0]       err_code, aref_cnt;
    logic [CNT_W-1:0] init_cycles;
    logic [2:0]       chk_state;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sdram_init_checker #(
        .T_PWRUP(8), .T_RP(2), .T_RFC(7), .N_AREF(2),
        .T_MRD(2), .T_DONE(8), .CNT_W(CNT_W)
    ) dut (
        .wb_clk_i      (clk),
        .wb_rst_i      (rst),
        .sdr_cke       (cke),
        .sdr_cs_n      (cs_n),
        .sdr_ras_n     (ras_n),
        .sdr_cas_n     (cas_n),
        .sdr_we_n      (we_n),
        .sdr_init_done (done),
        .init_ok       (init_ok),
        .init_err      (init_err),
        .err_code      (err_code),
        .aref_cnt      (aref_cnt),
        .init_cycles   (init_cycles),
        .chk_state     (chk_state)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One sampled cycle: drive, let the edge take it, look 1 time unit later.
    task automatic tick(input logic [3:0] c, input logic d);
        {cs_n, ras_n, cas_n, we_n} = c;
        done = d;
        @(posedge clk);
        #1;
    endtask

    task automatic nops(input int n, input logic d);
        for (int i = 0; i < n; i++) tick(C_NOP, d);
    endtask

    task automatic do_reset;
        rst = 1'b1;
        cke = 1'b1;
        {cs_n, ras_n, cas_n, we_n} = C_NOP;
        done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic to_wait_rfc;
        nops(8, 1'b0);
        tick(C_PRE, 1'b0);
        tick(C_NOP, 1'b0);
        tick(C_AREF, 1'b0);
    endtask

    task automatic to_mrs;
        to_wait_rfc();
        nops(6, 1'b0);
        tick(C_AREF, 1'b0);
        nops(6, 1'b0);
        tick(C_MRS, 1'b0);
    endtask

    task automatic check_legal_done(input string pfx);
        to_mrs();
        chk({pfx, "_state_wd"}, chk_state, 3);
        nops(3, 1'b0);
        tick(C_NOP, 1'b1);
        chk({pfx, "_ok"}, init_ok, 1);
        chk({pfx, "_err"}, init_err, 0);
        chk({pfx, "_code"}, err_code, 0);
        chk({pfx, "_aref"}, aref_cnt, 2);
        chk({pfx, "_cycles"}, init_cycles, 28);
        chk({pfx, "_state_run"}, chk_state, 4);
    endtask

    initial begin
        do_reset();
        chk("rst_ok", init_ok, 0);
        chk("rst_err", init_err, 0);
        chk("rst_code", err_code, 0);
        chk("rst_aref", aref_cnt, 0);
        chk("rst_cycles", init_cycles, 0);
        chk("rst_state", chk_state, 0);

        // Legal sequence, then init_done dropping while running.
        check_legal_done("t1");
        nops(4, 1'b1);
        chk("t1_hold_ok", init_ok, 1);
        chk("t1_hold_err", init_err, 0);
        tick(C_NOP, 1'b0);
        chk("t1_drop_err", init_err, 1);
        chk("t1_drop_code", err_code, 9);

        // PRE too early in the power-up window.
        do_reset();
        nops(5, 1'b0);
        chk("t2_pre_before", init_err, 0);
        tick(C_PRE, 1'b0);
        chk("t2_err", init_err, 1);
        chk("t2_code", err_code, 1);
        chk("t2_state", chk_state, 5);
        chk("t2_cycles", init_cycles, 5);
        nops(8, 1'b0);
        tick(C_PRE, 1'b0);
        chk("t2_sticky_code", err_code, 1);

        // Second AREF 3 cycles after the first.
        do_reset();
        to_wait_rfc();
        chk("t3_aref1", aref_cnt, 1);
        chk("t3_state", chk_state, 2);
        nops(2, 1'b0);
        tick(C_AREF, 1'b0);
        chk("t3_code", err_code, 4);
        chk("t3_ok", init_ok, 0);

        // Only one AREF before MRS.
        do_reset();
        to_wait_rfc();
        nops(6, 1'b0);
        tick(C_MRS, 1'b0);
        chk("t4a_code", err_code, 5);

        // init_done raised too early.
        do_reset();
        to_wait_rfc();
        tick(C_NOP, 1'b0);
        tick(C_NOP, 1'b1);
        chk("t4b_code", err_code, 8);
        chk("t4b_state", chk_state, 5);

        // init_done never arrives after MRS.
        do_reset();
        to_mrs();
        nops(7, 1'b0);
        chk("t5_gap7_err", init_err, 0);
        tick(C_NOP, 1'b0);
        chk("t5_err", init_err, 1);
        chk("t5_code", err_code, 7);

        // Reset in the middle, then a full legal replay.
        do_reset();
        to_wait_rfc();
        nops(3, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("t6_rst_state", chk_state, 0);
        chk("t6_rst_aref", aref_cnt, 0);
        chk("t6_rst_err", init_err, 0);
        rst = 1'b0;
        check_legal_done("t6");

        // AREF right after PRE violates tRP.
        do_reset();
        nops(8, 1'b0);
        tick(C_PRE, 1'b0);
        tick(C_AREF, 1'b0);
        chk("t7_code", err_code, 3);

        // A second PRE at a legal gap is out of order, not a timing error.
        do_reset();
        nops(8, 1'b0);
        tick(C_PRE, 1'b0);
        tick(C_NOP, 1'b0);
        tick(C_PRE, 1'b0);
        chk("t8_code", err_code, 2);

        // CKE low after power-up; and together with early done, done wins.
        do_reset();
        nops(8, 1'b0);
        tick(C_PRE, 1'b0);
        cke = 1'b0;
        tick(C_NOP, 1'b0);
        chk("t9_cke_code", err_code, 10);
        do_reset();
        nops(8, 1'b0);
        tick(C_PRE, 1'b0);
        cke = 1'b0;
        tick(C_NOP, 1'b1);
        chk("t9_prio_code", err_code, 8);

        // Completion and tMRD violation in the same sample: error wins.
        do_reset();
        to_mrs();
        tick(C_MRS, 1'b1);
        chk("t10_code", err_code, 6);
        chk("t10_ok", init_ok, 0);
        chk("t10_state", chk_state, 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
